// File: rtl/dsi_panel_sequencer.sv
// dsi_panel_sequencer: power-up, reset and init sequencer for a DSI panel.
// It steps the regulators and the panel reset with dwell timing, sends the
// init commands, can optionally send a test pattern, and then hands the
// command channel to the host.
// Optional feature macro: DSI_SEQ_TP_EN adds the test-pattern states and the
// line counter. Without it, tp_mode_i is ignored and init always ends in IDLE.
module dsi_panel_sequencer #(
    parameter int              CMD_W      = 8,
    parameter int              CNT_W      = 32,
    parameter int              T_PWR_ON   = 11500000,
    parameter int              T_RST_LOW  = 230000,
    parameter int              T_RST_HIGH = 46000,
    parameter int              T_VDD      = 230000,
    parameter int              T_INIT     = 230000,
    parameter int              N_INIT     = 1,
    parameter logic [CMD_W-1:0] INIT_BASE = 8'h89,
    parameter logic [CMD_W-1:0] TP_FIRST  = 8'hCF,
    parameter logic [CMD_W-1:0] TP_NEXT   = 8'hD9,
    parameter int              LINE_MAX   = 240,
    parameter int              TX_TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             nsys_reset,
    input  logic             tp_mode_i,
    input  logic             restart_i,
    input  logic             host_cmd_valid_i,
    input  logic [CMD_W-1:0] host_cmd_i,
    output logic             host_cmd_ready_o,
    input  logic             tx_finish_i,
    output logic [CMD_W-1:0] cmd_o,
    output logic             write_cmd_o,
    output logic             reg_1v8_en,
    output logic             reg_3v0_en,
    output logic             lcd_rst,
    output logic             bl_en,
    output logic             fifo_reset,
    output logic             timeout_o
);

    localparam logic [3:0] PWR_ON    = 4'd0;
    localparam logic [3:0] RST_LOW   = 4'd1;
    localparam logic [3:0] RST_HIGH  = 4'd2;
    localparam logic [3:0] VDD_ON    = 4'd3;
    localparam logic [3:0] INIT_SEND = 4'd4;
    localparam logic [3:0] INIT_WAIT = 4'd5;
    localparam logic [3:0] INIT_DLY  = 4'd6;
`ifdef DSI_SEQ_TP_EN
    localparam logic [3:0] TP_SEND   = 4'd7;
    localparam logic [3:0] TP_WAIT   = 4'd8;
`endif
    localparam logic [3:0] IDLE      = 4'd9;
    localparam logic [3:0] HOST_WAIT = 4'd10;

    logic [3:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       idx;
`ifdef DSI_SEQ_TP_EN
    logic [15:0]      line;
`else
    logic             unused_tp;
    assign unused_tp = ^{tp_mode_i, TP_FIRST, TP_NEXT, LINE_MAX};
`endif

    logic in_wait;
    logic tx_seen;
    logic tmo_hit;

    // Wait-state decode; the strobe cycle itself never counts as a finish.
    always_comb begin
        in_wait = (state == INIT_WAIT) || (state == HOST_WAIT);
`ifdef DSI_SEQ_TP_EN
        if (state == TP_WAIT) in_wait = 1'b1;
`endif
        tx_seen = in_wait && !write_cmd_o && tx_finish_i;
        tmo_hit = in_wait && (cnt == CNT_W'(TX_TIMEOUT - 1));
    end

    assign host_cmd_ready_o = (state == IDLE);

    // Main sequencer: dwell countdown, wait-state timeout, per-state actions.
    always_ff @(posedge clk or negedge nsys_reset) begin
        if (!nsys_reset) begin
            state       <= PWR_ON;
            cnt         <= '0;
            idx         <= '0;
`ifdef DSI_SEQ_TP_EN
            line        <= '0;
`endif
            cmd_o       <= '0;
            write_cmd_o <= 1'b0;
            reg_1v8_en  <= 1'b0;
            reg_3v0_en  <= 1'b0;
            lcd_rst     <= 1'b0;
            bl_en       <= 1'b0;
            fifo_reset  <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            write_cmd_o <= 1'b0;
            if (in_wait) begin
                if (tx_seen) begin
                    cnt <= '0;
                    case (state)
                        INIT_WAIT: begin
                            cnt   <= CNT_W'(T_INIT);
                            state <= INIT_DLY;
                        end
`ifdef DSI_SEQ_TP_EN
                        TP_WAIT: begin
                            state <= (line < 16'(LINE_MAX)) ? TP_SEND : IDLE;
                        end
`endif
                        default: state <= IDLE;
                    endcase
                end else if (tmo_hit) begin
                    timeout_o <= 1'b1;
                    cnt       <= '0;
                    state     <= RST_LOW;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                case (state)
                    PWR_ON: begin
                        reg_1v8_en <= 1'b1;
                        lcd_rst    <= 1'b1;
                        bl_en      <= 1'b1;
                        fifo_reset <= 1'b1;
                        cnt        <= CNT_W'(T_PWR_ON);
                        state      <= RST_LOW;
                    end
                    RST_LOW: begin
                        lcd_rst    <= 1'b0;
                        fifo_reset <= 1'b0;
                        cnt        <= CNT_W'(T_RST_LOW);
                        state      <= RST_HIGH;
                    end
                    RST_HIGH: begin
                        lcd_rst    <= 1'b1;
                        fifo_reset <= 1'b1;
                        cnt        <= CNT_W'(T_RST_HIGH);
                        state      <= VDD_ON;
                    end
                    VDD_ON: begin
                        fifo_reset <= 1'b0;
                        reg_3v0_en <= 1'b1;
                        cnt        <= CNT_W'(T_VDD);
                        idx        <= '0;
                        state      <= INIT_SEND;
                    end
                    INIT_SEND: begin
                        cmd_o       <= INIT_BASE + CMD_W'(idx);
                        write_cmd_o <= 1'b1;
                        state       <= INIT_WAIT;
                    end
                    INIT_DLY: begin
                        if (idx < 4'(N_INIT - 1)) begin
                            idx   <= idx + 1'b1;
                            state <= INIT_SEND;
`ifdef DSI_SEQ_TP_EN
                        end else if (tp_mode_i) begin
                            line  <= '0;
                            state <= TP_SEND;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end
`ifdef DSI_SEQ_TP_EN
                    TP_SEND: begin
                        cmd_o       <= (line == 16'd0) ? TP_FIRST : TP_NEXT;
                        write_cmd_o <= 1'b1;
                        line        <= line + 1'b1;
                        state       <= TP_WAIT;
                    end
`endif
                    IDLE: begin
                        if (restart_i) begin
                            reg_3v0_en <= 1'b0;
                            lcd_rst    <= 1'b0;
                            bl_en      <= 1'b0;
                            timeout_o  <= 1'b0;
                            state      <= PWR_ON;
                        end else if (host_cmd_valid_i) begin
                            cmd_o       <= host_cmd_i;
                            write_cmd_o <= 1'b1;
                            state       <= HOST_WAIT;
                        end
                    end
                    default: state <= PWR_ON;
                endcase
            end
        end
    end

endmodule
